// File: rtl/arashi_sched_pkg.sv
// ============================================================================
//  Module   : arashi_sched_pkg
//  Purpose  : Shared types and helpers for the arashi round-robin scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arashi_sched_pkg;

   // Scheduler state: IDLE means no grant is presented, GRANT means one is.
   typedef enum logic {
      SCHED_IDLE  = 1'b0,
      SCHED_GRANT = 1'b1
   } sched_state_t;

   // Bits needed to count 0..max_burst consecutive grants.
   function automatic int burst_cnt_width(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage : arashi_sched_pkg

`default_nettype wire

// File: rtl/arashi_rr_pick.sv
// ============================================================================
//  Module   : arashi_rr_pick
//  Purpose  : Combinational round-robin picker. Finds the first set bit of
//             'eligible' at or after index 'start', wrapping modulo
//             THREAD_NUM.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arashi_rr_pick #(
   parameter int THREAD_NUM_WIDTH = 3,
   localparam int THREAD_NUM      = 1 << THREAD_NUM_WIDTH
) (
   input  logic [THREAD_NUM-1:0]       eligible,
   input  logic [THREAD_NUM_WIDTH-1:0] start,
   output logic                        found,
   output logic [THREAD_NUM_WIDTH-1:0] idx
);

   logic [2*THREAD_NUM-1:0]     dbl;
   logic [THREAD_NUM-1:0]       rot;
   logic [THREAD_NUM_WIDTH-1:0] off;

   assign dbl = {eligible, eligible};

   // Rotate the doubled vector right by 'start' so bit 0 of 'rot' is thread 'start'.
   always_comb begin
      logic [THREAD_NUM_WIDTH:0] pos;
      rot = '0;
      pos = '0;
      for (int i = 0; i < THREAD_NUM; i++) begin
         pos    = {1'b0, start} + (THREAD_NUM_WIDTH+1)'(i);
         rot[i] = dbl[pos];
      end
   end

   // Priority encoder: lowest set bit of the rotated vector is the winner's offset.
   always_comb begin
      found = 1'b0;
      off   = '0;
      for (int i = THREAD_NUM - 1; i >= 0; i--) begin
         if (rot[i]) begin
            found = 1'b1;
            off   = i[THREAD_NUM_WIDTH-1:0];
         end
      end
   end

   // Undo the rotation; the add wraps naturally at THREAD_NUM.
   assign idx = start + off;

endmodule : arashi_rr_pick

`default_nettype wire

// File: rtl/arashi_rr_sched.sv
// ============================================================================
//  Module   : arashi_rr_sched
//  Purpose  : Round-robin thread scheduler with registered grant, valid/accept
//             handshake, per-thread masking and optional burst hold.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arashi_rr_sched
   import arashi_sched_pkg::*;
#(
   parameter int THREAD_NUM_WIDTH = 3,
   parameter int MAX_BURST        = 4,
   localparam int THREAD_NUM      = 1 << THREAD_NUM_WIDTH,
   localparam int BURST_W         = burst_cnt_width(MAX_BURST)
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [THREAD_NUM-1:0]       avail,
   input  logic [THREAD_NUM-1:0]       mask,
   input  logic                        burst_en,
   input  logic                        accept,
   output logic                        valid,
   output logic [THREAD_NUM_WIDTH-1:0] thread_id,
   output logic [BURST_W-1:0]          burst_cnt
);

   localparam logic [THREAD_NUM_WIDTH-1:0] IDX_ONE   = 1;
   localparam logic [BURST_W-1:0]          CNT_ONE   = 1;
   localparam logic [BURST_W-1:0]          CNT_LIMIT = BURST_W'(MAX_BURST);

   sched_state_t                state;
   logic [THREAD_NUM_WIDTH-1:0] last;
   logic [THREAD_NUM-1:0]       eligible;
   logic                        decide;
   logic                        burst_hold;
   logic                        pick_found;
   logic [THREAD_NUM_WIDTH-1:0] pick_idx;
   logic [THREAD_NUM_WIDTH-1:0] pick_start;

   assign eligible   = avail & ~mask;
   assign valid      = (state == SCHED_GRANT);
   // A pending grant blocks any new decision until it is accepted.
   assign decide     = (state == SCHED_IDLE) || accept;
   // With MAX_BURST=1 the count is already at the limit, so this never fires.
   assign burst_hold = burst_en && (state == SCHED_GRANT) &&
                       eligible[thread_id] && (burst_cnt < CNT_LIMIT);
   // The previously granted thread becomes lowest priority.
   assign pick_start = last + IDX_ONE;

   arashi_rr_pick #(
      .THREAD_NUM_WIDTH (THREAD_NUM_WIDTH)
   ) u_pick (
      .eligible (eligible),
      .start    (pick_start),
      .found    (pick_found),
      .idx      (pick_idx)
   );

   // Grant state machine: burst hold first, then rotation, else go idle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= SCHED_IDLE;
         thread_id <= '0;
         burst_cnt <= '0;
         last      <= '1;
      end else if (decide) begin
         if (burst_hold) begin
            burst_cnt <= burst_cnt + CNT_ONE;
         end else if (pick_found) begin
            state     <= SCHED_GRANT;
            thread_id <= pick_idx;
            last      <= pick_idx;
            burst_cnt <= CNT_ONE;
         end else begin
            state     <= SCHED_IDLE;
            burst_cnt <= '0;
         end
      end
   end

endmodule : arashi_rr_sched

`default_nettype wire

// File: tb/tb_arashi_rr_sched.sv
// ============================================================================
//  Module   : tb_arashi_rr_sched
//  Purpose  : Self-checking bench for arashi_rr_sched (3-bit ids, burst 4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arashi_rr_sched;

   localparam int W  = 3;
   localparam int N  = 1 << W;
   localparam int MB = 4;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic [N-1:0] avail = '0;
   logic [N-1:0] mask = '0;
   logic         burst_en = 1'b0;
   logic         accept = 1'b0;
   logic         valid;
   logic [W-1:0] thread_id;
   logic [2:0]   burst_cnt;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state, in plain integers.
   bit m_valid;
   int m_tid;
   int m_cnt;
   int m_last;

   arashi_rr_sched #(
      .THREAD_NUM_WIDTH (W),
      .MAX_BURST        (MB)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .avail     (avail),
      .mask      (mask),
      .burst_en  (burst_en),
      .accept    (accept),
      .valid     (valid),
      .thread_id (thread_id),
      .burst_cnt (burst_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_valid = 1'b0;
      m_tid   = 0;
      m_cnt   = 0;
      m_last  = N - 1;
   endtask

   // Advance one rising edge, update the model from the inputs seen at that
   // edge, then settle 1 time unit past the edge.
   task automatic tick();
      logic [N-1:0] elig;
      bit           hit;
      @(posedge clk);
      if (!m_valid || accept) begin
         elig = avail & ~mask;
         if (burst_en && m_valid && elig[m_tid] && m_cnt < MB) begin
            m_cnt = m_cnt + 1;
         end else begin
            hit = 1'b0;
            for (int k = 1; k <= N; k++) begin
               if (!hit && elig[(m_last + k) % N]) begin
                  hit    = 1'b1;
                  m_tid  = (m_last + k) % N;
                  m_last = m_tid;
               end
            end
            m_valid = hit;
            m_cnt   = hit ? 1 : 0;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      model_reset();
      @(posedge clk);
      #3;
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      avail = '0; mask = '0; burst_en = 1'b0; accept = 1'b0;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         tick();
         vectors++;
         if (valid !== 1'b0 || thread_id !== 3'd0 || burst_cnt !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_idle cyc=%0d got v=%b id=%0d cnt=%0d want v=0 id=0 cnt=0",
                     c, valid, thread_id, burst_cnt);
         end
      end
   endtask

   task automatic test_rotation();
      int exp_ids [6] = '{0, 2, 7, 0, 2, 7};
      do_reset();
      avail = 8'b1000_0101; mask = '0; burst_en = 1'b0; accept = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         vectors++;
         if (valid !== 1'b1 || thread_id !== exp_ids[c][W-1:0] ||
             thread_id !== m_tid[W-1:0]) begin
            miscompares++;
            $display("FAIL rotation cyc=%0d got v=%b id=%0d want v=1 id=%0d",
                     c, valid, thread_id, exp_ids[c]);
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      avail = 8'h04; mask = '0; burst_en = 1'b0; accept = 1'b1;
      tick();
      vectors++;
      if (valid !== 1'b1 || thread_id !== 3'd2) begin
         miscompares++;
         $display("FAIL stall_first got v=%b id=%0d want v=1 id=2", valid, thread_id);
      end
      accept = 1'b0; avail = 8'h80;
      for (int c = 0; c < 3; c++) begin
         tick();
         vectors++;
         if (valid !== 1'b1 || thread_id !== 3'd2 || burst_cnt !== 3'd1) begin
            miscompares++;
            $display("FAIL stall_hold cyc=%0d got v=%b id=%0d cnt=%0d want v=1 id=2 cnt=1",
                     c, valid, thread_id, burst_cnt);
         end
      end
      accept = 1'b1;
      tick();
      vectors++;
      if (valid !== 1'b1 || thread_id !== 3'd7) begin
         miscompares++;
         $display("FAIL stall_release got v=%b id=%0d want v=1 id=7", valid, thread_id);
      end
   endtask

   task automatic test_burst();
      int exp_ids [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      int exp_cnt [9] = '{1, 2, 3, 4, 1, 2, 3, 4, 1};
      do_reset();
      avail = 8'h03; mask = '0; burst_en = 1'b1; accept = 1'b1;
      for (int c = 0; c < 9; c++) begin
         tick();
         vectors++;
         if (valid !== 1'b1 || thread_id !== exp_ids[c][W-1:0] ||
             burst_cnt !== exp_cnt[c][2:0]) begin
            miscompares++;
            $display("FAIL burst cyc=%0d got id=%0d cnt=%0d want id=%0d cnt=%0d",
                     c, thread_id, burst_cnt, exp_ids[c], exp_cnt[c]);
         end
      end
      // Dropping burst_en mid-burst forces rotation at the next decision.
      tick();
      burst_en = 1'b0;
      tick();
      vectors++;
      if (thread_id !== 3'd1 || burst_cnt !== 3'd1) begin
         miscompares++;
         $display("FAIL burst_off got id=%0d cnt=%0d want id=1 cnt=1", thread_id, burst_cnt);
      end
   endtask

   task automatic test_mask();
      int exp_ids [4] = '{0, 3, 0, 3};
      do_reset();
      avail = 8'hFF; mask = 8'hF6; burst_en = 1'b0; accept = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         vectors++;
         if (valid !== 1'b1 || thread_id !== exp_ids[c][W-1:0]) begin
            miscompares++;
            $display("FAIL mask cyc=%0d got v=%b id=%0d want v=1 id=%0d",
                     c, valid, thread_id, exp_ids[c]);
         end
      end
      mask = 8'hFF;
      tick();
      vectors++;
      if (valid !== 1'b0 || thread_id !== 3'd3 || burst_cnt !== 3'd0) begin
         miscompares++;
         $display("FAIL mask_all got v=%b id=%0d cnt=%0d want v=0 id=3 cnt=0",
                  valid, thread_id, burst_cnt);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      avail = 8'h20; mask = '0; burst_en = 1'b0; accept = 1'b0;
      tick();
      vectors++;
      if (valid !== 1'b1 || thread_id !== 3'd5) begin
         miscompares++;
         $display("FAIL areset_pre got v=%b id=%0d want v=1 id=5", valid, thread_id);
      end
      #1;
      rstn = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (valid !== 1'b0 || thread_id !== 3'd0 || burst_cnt !== 3'd0) begin
         miscompares++;
         $display("FAIL areset_now got v=%b id=%0d cnt=%0d want v=0 id=0 cnt=0",
                  valid, thread_id, burst_cnt);
      end
      #1;
      rstn = 1'b1;
      tick();
      vectors++;
      if (valid !== 1'b1 || thread_id !== 3'd5 || burst_cnt !== 3'd1) begin
         miscompares++;
         $display("FAIL areset_post got v=%b id=%0d cnt=%0d want v=1 id=5 cnt=1",
                  valid, thread_id, burst_cnt);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         avail    = N'($urandom);
         mask     = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'(0);
         accept   = ($urandom_range(0, 3) != 0);
         burst_en = ($urandom_range(0, 2) != 0);
         tick();
         vectors++;
         if (valid !== m_valid || thread_id !== m_tid[W-1:0] ||
             burst_cnt !== m_cnt[2:0]) begin
            miscompares++;
            $display("FAIL random cyc=%0d got v=%b id=%0d cnt=%0d want v=%b id=%0d cnt=%0d",
                     c, valid, thread_id, burst_cnt, m_valid, m_tid, m_cnt);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_rotation();
      test_stall();
      test_burst();
      test_mask();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_arashi_rr_sched

`default_nettype wire

// File: doc/arashi_rr_sched.md
# arashi_rr_sched

Parametrised round-robin thread scheduler with registered grant, valid/accept handshake, per-thread masking and an optional burst mode that holds a thread for up to `MAX_BURST` consecutive grants. It sits between the per-thread availability flags and the single issue slot of the pipeline. It selects one eligible thread per accepted grant, with fair wrap-around rotation starting after the last granted thread.

## Interface
Parameters:
- `THREAD_NUM_WIDTH`, default 3: thread-index width. `THREAD_NUM = 1 << THREAD_NUM_WIDTH`. Any value ≥ 1 is legal.
- `MAX_BURST`, default 4: maximum consecutive grants to one thread when burst mode is on. Must be ≥ 1.

Ports:
- `clk` input 1: single clock, rising edge.
- `rstn` input 1: reset, asynchronous, active-low.
- `avail` input `THREAD_NUM`: per-thread ready-to-issue flags.
- `mask` input `THREAD_NUM`: 1 excludes the thread from selection.
- `burst_en` input 1: enables burst hold.
- `accept` input 1: downstream consumes the current grant.
- `valid` output 1: grant present.
- `thread_id` output `THREAD_NUM_WIDTH`: granted thread.
- `burst_cnt` output `$clog2(MAX_BURST+1)`: number of consecutive grants to `thread_id`, starting at 1 for a new thread.

## Operation
- `eligible = avail & ~mask`, sampled only at a decision edge.
- A decision edge is any edge where `!valid || accept`.
- States:
  - IDLE: `valid=0`.
  - GRANT: `valid=1`, waiting for `accept`.
- Stall rule: in GRANT with `accept=0`, `thread_id`, `valid` and `burst_cnt` hold. This holds even if the granted thread's `avail` drops or its `mask` rises. A grant is never withdrawn.
- Decision order:
  1. Burst hold. If `burst_en`, `valid`, `eligible[thread_id]` and `burst_cnt < MAX_BURST`, re-grant `thread_id` and increment `burst_cnt`.
  2. Rotation. Otherwise, search `eligible` starting at `last+1` and wrapping mod `THREAD_NUM`. The first set bit wins: `thread_id` takes that index, `last` takes that index, `burst_cnt=1`, and the state goes to GRANT.
  3. No eligible thread. The state goes to IDLE, `valid=0`, and `thread_id`/`last` keep their previous values. `burst_cnt` clears to 0.
- `last` is an internal pointer and is updated only on a new grant.
- The last granted thread is the lowest priority in the next search. With a single eligible thread it is re-granted every decision, bursting or not.
- With `MAX_BURST=1`, `burst_en` has no effect.
- A change to `burst_en` takes effect at the next decision edge. Clearing it mid-burst forces rotation at that decision.
- Index arithmetic is unsigned, `THREAD_NUM_WIDTH` wide, and wraps naturally: `THREAD_NUM-1` + 1 gives 0.

## Timing
- Reset: `valid=0`, `thread_id=0`, `burst_cnt=0`, `last=THREAD_NUM-1`, state IDLE. The first search therefore starts at thread 0.
- Reset assertion clears state immediately, without waiting for a clock edge. After `rstn` rises, the first decision happens at the next rising edge.
- Latency: `avail` set in cycle n gives `valid` in cycle n+1, since outputs are registered. There is no combinational path from inputs to outputs.
- Throughput: one grant per cycle while `accept=1` is held.
- `accept` while `valid=0` is ignored; it is treated as a decision edge anyway.

## Structure
- Package `arashi_sched_pkg` holds:
  - `typedef enum logic {SCHED_IDLE, SCHED_GRANT} sched_state_t`
  - a width helper function for `burst_cnt`.
- Sub-module `arashi_rr_pick`, purely combinational:
  - Inputs: `eligible`, `start`.
  - Outputs: `found`, `idx`.
  - Implementation: rotate-right of `{eligible, eligible}` by `start`, then a priority encoder for the lowest set bit, then add `start` mod `THREAD_NUM`.
  - Generic for any `THREAD_NUM_WIDTH`; no width-specific generate branches.
- The top level holds the state register, `last`, the burst counter and the decision logic.

## Test plan
All scenarios use `THREAD_NUM_WIDTH=3`, `MAX_BURST=4`.

1. Reset then idle: `avail=0` after `rstn` rises → `valid=0`, `thread_id=0`, `burst_cnt=0` for 10 cycles.
2. Rotation with wrap: `avail=8'b1000_0101`, `accept=1`, `burst_en=0` → `thread_id` = 0,2,7,0,2,7 on consecutive cycles, `valid=1` throughout.
3. Stall:
   - Grant on thread 2, then `accept=0` for 3 cycles while `avail` changes to `8'h80` → `thread_id=2`, `valid=1` held.
   - `accept=1` for one cycle → next grant is 7.
4. Burst: `burst_en=1`, `avail=8'h03`, `accept=1` → `thread_id` = 0,0,0,0,1,1,1,1,0 with `burst_cnt` = 1,2,3,4,1,2,3,4,1.
5. Mask: `avail=8'hFF`, `mask=8'hF6` → grants 0,3,0,3. Then set `mask=8'hFF` → `valid` drops after the current grant is accepted, and `thread_id` holds 3.
6. Asynchronous reset mid-grant: pulse `rstn` low between edges while `valid=1` on thread 5 → `valid=0`, `thread_id=0` immediately. After release with `avail=8'h20`, the first grant is 5.
